// File: rtl/spm_port_arb.sv
// spm_port_arb: round-robin two-master sequencer for one SPM RAM port (3-cycle req/rdy handshake).
// Define SPM_ARB_LOCK_EN to let an owner keep the port across accesses via mN_lock_i.
module spm_port_arb #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req_i,
    input  logic              m0_rw_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wr_data_i,
    input  logic              m0_lock_i,
    output logic              m0_rdy_o,
    output logic [DATA_W-1:0] m0_rd_data_o,
    input  logic              m1_req_i,
    input  logic              m1_rw_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wr_data_i,
    input  logic              m1_lock_i,
    output logic              m1_rdy_o,
    output logic [DATA_W-1:0] m1_rd_data_o,
    output logic [ADDR_W-1:0] spm_addr_o,
    output logic [DATA_W-1:0] spm_wr_data_o,
    output logic              spm_we_o,
    input  logic [DATA_W-1:0] spm_rd_data_i,
    output logic              owner_o,
    output logic              busy_o
);
`ifdef SPM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              rw_q;
    logic              owner_q;
    logic              lock_q;
    logic              own_req;
    logic              own_lock;
    logic              hold;
    logic              gnt;
    logic              done;

    assign own_req  = owner_q ? m1_req_i : m0_req_i;
    assign own_lock = owner_q ? m1_lock_i : m0_lock_i;
    // A held lock beats round-robin only while its owner keeps requesting
    assign hold     = LOCK_EN && lock_q && own_req;
    assign gnt      = hold ? owner_q : (m0_req_i && m1_req_i) ? ~owner_q : m1_req_i;
    assign done     = state_q == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rw_q    <= 1'b0;
            owner_q <= 1'b1;
            lock_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    we_q   <= 1'b0;
                    lock_q <= lock_q && own_req;
                    if (m0_req_i || m1_req_i) begin
                        addr_q  <= gnt ? m1_addr_i : m0_addr_i;
                        wdata_q <= gnt ? m1_wr_data_i : m0_wr_data_i;
                        rw_q    <= gnt ? m1_rw_i : m0_rw_i;
                        we_q    <= ~(gnt ? m1_rw_i : m0_rw_i);
                        owner_q <= gnt;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    we_q    <= 1'b0;
                    state_q <= DONE;
                end
                DONE: begin
                    lock_q  <= own_lock;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spm_addr_o    = addr_q;
    assign spm_wr_data_o = wdata_q;
    assign spm_we_o      = we_q;
    assign owner_o       = owner_q;
    assign busy_o        = state_q != IDLE;
    assign m0_rdy_o      = done && !owner_q;
    assign m1_rdy_o      = done && owner_q;
    assign m0_rd_data_o  = (m0_rdy_o && rw_q) ? spm_rd_data_i : '0;
    assign m1_rd_data_o  = (m1_rdy_o && rw_q) ? spm_rd_data_i : '0;
endmodule

// File: tb/tb_spm_port_arb.sv
// tb_spm_port_arb: directed stimulus with a rdy-driven scoreboard monitor and a behavioural SPM RAM.
module tb_spm_port_arb;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        m0_req = 0, m0_rw = 0, m0_lock = 0, m0_rdy;
    logic [11:0] m0_addr = 0;
    logic [31:0] m0_wd = 0, m0_rd;
    logic        m1_req = 0, m1_rw = 0, m1_lock = 0, m1_rdy;
    logic [11:0] m1_addr = 0;
    logic [31:0] m1_wd = 0, m1_rd;
    logic [11:0] spm_addr;
    logic [31:0] spm_wd, spm_rd;
    logic        spm_we, owner, busy;
    logic [31:0] mem [4096];
    logic [32:0] sb [$];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    spm_port_arb dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_rw_i(m0_rw), .m0_addr_i(m0_addr), .m0_wr_data_i(m0_wd),
        .m0_lock_i(m0_lock), .m0_rdy_o(m0_rdy), .m0_rd_data_o(m0_rd),
        .m1_req_i(m1_req), .m1_rw_i(m1_rw), .m1_addr_i(m1_addr), .m1_wr_data_i(m1_wd),
        .m1_lock_i(m1_lock), .m1_rdy_o(m1_rdy), .m1_rd_data_o(m1_rd),
        .spm_addr_o(spm_addr), .spm_wr_data_o(spm_wd), .spm_we_o(spm_we),
        .spm_rd_data_i(spm_rd), .owner_o(owner), .busy_o(busy)
    );

    initial for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 | i;

    always @(posedge clk) begin
        if (spm_we) mem[spm_addr] <= spm_wd;
        spm_rd <= mem[spm_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rdy strobe consumes one expected {master, rd_data} entry
    always @(negedge clk) begin
        if (rst_n && (m0_rdy || m1_rdy)) begin
            chk("rdy_onehot", {31'd0, m0_rdy && m1_rdy}, 32'd0);
            if (sb.size() == 0) chk("unexpected_rdy", {31'd0, m1_rdy}, 32'hFFFF_FFFF);
            else begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("rdy_master", {31'd0, m1_rdy}, {31'd0, e[32]});
                chk("rd_data", m1_rdy ? m1_rd : m0_rd, e[31:0]);
                chk("other_rd_zero", m1_rdy ? m0_rd : m1_rd, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit m, input bit rw, input logic [11:0] a, input logic [31:0] d,
                          input logic [31:0] exp);
        bit seen = 0;
        sb.push_back({m, rw ? exp : 32'd0});
        if (m) begin m1_req = 1; m1_rw = rw; m1_addr = a; m1_wd = d; end
        else begin m0_req = 1; m0_rw = rw; m0_addr = a; m0_wd = d; end
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = m ? m1_rdy : m0_rdy;
        end
        if (!seen) chk("access_timeout", 32'd0, 32'd1);
        m0_req = 0; m1_req = 0;
        tick();
    endtask

    // Both masters read continuously; seq bit k is the expected owner of grant k
    task automatic run_grants(input int n, input logic [7:0] seq, input int m1_max, input bit lk);
        int k = 0, cyc = 0, last = 0, m1cnt = 0;
        for (int i = 0; i < n; i++) sb.push_back({seq[i], seq[i] ? 32'h1000_0011 : 32'hDEAD_BEEF});
        m0_rw = 1; m0_addr = 12'h010; m1_rw = 1; m1_addr = 12'h011; m1_lock = lk;
        m0_req = 1; m1_req = 1;
        while (k < n && cyc < 60) begin
            tick();
            cyc++;
            if (m0_rdy || m1_rdy) begin
                chk("grant_owner", {31'd0, owner}, {31'd0, seq[k]});
                if (k > 0) chk("rdy_spacing", cyc - last, 3);
                last = cyc;
                if (m1_rdy && ++m1cnt == m1_max) m1_req = 0;
                k++;
            end
        end
        if (k < n) chk("grants_timeout", k, n);
        m0_req = 0; m1_req = 0; m1_lock = 0;
        tick();
        chk("idle_after_run", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_we", {31'd0, spm_we}, 32'd0);
        chk("rst_addr", {20'd0, spm_addr}, 32'd0);
        chk("rst_wd", spm_wd, 32'd0);
        chk("rst_owner", {31'd0, owner}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdy", {30'd0, m1_rdy, m0_rdy}, 32'd0);
        rst_n = 1;
        tick();
        // 1: m0 write, spm_we exactly in T1
        sb.push_back({1'b0, 32'd0});
        m0_req = 1; m0_rw = 0; m0_addr = 12'h010; m0_wd = 32'hDEAD_BEEF;
        chk("t1_we_t0", {31'd0, spm_we}, 32'd0);
        tick();
        chk("t1_we_t1", {31'd0, spm_we}, 32'd1);
        chk("t1_addr", {20'd0, spm_addr}, 32'h010);
        chk("t1_wd", spm_wd, 32'hDEAD_BEEF);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_we_t2", {31'd0, spm_we}, 32'd0);
        chk("t1_m0_rdy", {31'd0, m0_rdy}, 32'd1);
        m0_req = 0;
        tick();
        chk("t1_idle_t3", {31'd0, busy}, 32'd0);
        // 2: m1 reads it back
        access(1, 1, 12'h010, 32'd0, 32'hDEAD_BEEF);
        // 6: m0 drops req during ACCESS
        sb.push_back({1'b0, 32'h1000_0FFF});
        m0_req = 1; m0_rw = 1; m0_addr = 12'hFFF;
        tick();
        m0_req = 0;
        tick();
        chk("t6_rdy", {31'd0, m0_rdy}, 32'd1);
        tick();
        chk("t6_idle_t3", {31'd0, busy}, 32'd0);
        chk("t6_no_rdy_t3", {31'd0, m0_rdy}, 32'd0);
        // 3: continuous contention from reset
        rst_n = 0; #2; rst_n = 1;
        tick();
        run_grants(6, 8'b0010_1010, 99, 0);
        // 4: async reset during a write ACCESS
        m0_req = 1; m0_rw = 0; m0_addr = 12'h030; m0_wd = 32'h1234_5678;
        tick();
        chk("t4_we_before", {31'd0, spm_we}, 32'd1);
        #1 rst_n = 0;
        m0_req = 0;
        #1;
        chk("t4_we_async", {31'd0, spm_we}, 32'd0);
        chk("t4_busy_async", {31'd0, busy}, 32'd0);
        chk("t4_owner_async", {31'd0, owner}, 32'd1);
        #1 rst_n = 1;
        tick();
        run_grants(2, 8'b0000_0010, 99, 0);
        // 5: m1 with lock against contending m0 (owner first moved to m0)
        access(0, 0, 12'h040, 32'h5555_AAAA, 32'd0);
`ifdef SPM_ARB_LOCK_EN
        run_grants(4, 8'b0000_0111, 3, 1);
`else
        run_grants(4, 8'b0000_0101, 3, 1);
`endif
        repeat (4) tick();
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
